// File: rtl/key_conditioner.sv
// key_conditioner: turns raw active-low push-buttons into debounced levels and
// one-cycle press/release pulses. Each key has its own 2-flop synchronizer,
// debounce counter and 4-state FSM. All outputs are registered.
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat press pulses while held).
module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Last counter value of a debounce window: a change is accepted when the
    // counter has reached this value and the new level is still present.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets that cannot work at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic [NUM_KEYS-1:0] sync1_d, sync1_q;
    logic [NUM_KEYS-1:0] sync2_d, sync2_q;
    state_t              state_d [NUM_KEYS];
    state_t              state_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
    logic [NUM_KEYS-1:0] pressed_d, pressed_q;
    logic [NUM_KEYS-1:0] press_pulse_d, press_pulse_q;
    logic [NUM_KEYS-1:0] release_pulse_d, release_pulse_q;

`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [31:0] REP_FIRST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] REP_NEXT  = 32'(REPEAT_PERIOD - 1);

    // rep_arm marks that the first (long) repeat delay has already elapsed.
    logic [31:0]         rep_cnt_d [NUM_KEYS];
    logic [31:0]         rep_cnt_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] rep_arm_d, rep_arm_q;
`endif

    // Synchronizer inputs: invert so that 1 means pressed.
    always_comb begin
        sync1_d = ~key_n;
        sync2_d = sync1_q;
    end

    // Per-key debounce FSM: next state, counter and registered-output values.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k]         = state_q[k];
            cnt_d[k]           = cnt_q[k];
            pressed_d[k]       = pressed_q[k];
            press_pulse_d[k]   = 1'b0;
            release_pulse_d[k] = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
            rep_cnt_d[k] = 32'd0;
            rep_arm_d[k] = 1'b0;
`endif
            case (state_q[k])
                ST_IDLE: begin
                    cnt_d[k]     = '0;
                    pressed_d[k] = 1'b0;
                    if (sync2_q[k]) begin
                        state_d[k] = ST_PRESS_WAIT;
                    end else begin
                        state_d[k] = ST_IDLE;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!sync2_q[k]) begin
                        // Bounce: drop back without any pulse.
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k]       = ST_HELD;
                        cnt_d[k]         = '0;
                        pressed_d[k]     = 1'b1;
                        press_pulse_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    cnt_d[k]     = '0;
                    pressed_d[k] = 1'b1;
                    if (!sync2_q[k]) begin
                        state_d[k] = ST_RELEASE_WAIT;
                    end else begin
                        state_d[k] = ST_HELD;
`ifdef KEY_AUTO_REPEAT_EN
                        rep_arm_d[k] = rep_arm_q[k];
                        if (rep_cnt_q[k] == (rep_arm_q[k] ? REP_NEXT : REP_FIRST)) begin
                            press_pulse_d[k] = 1'b1;
                            rep_cnt_d[k]     = 32'd0;
                            rep_arm_d[k]     = 1'b1;
                        end else begin
                            rep_cnt_d[k] = rep_cnt_q[k] + 32'd1;
                        end
`endif
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (sync2_q[k]) begin
                        // Release bounce: back to held, no pulse.
                        state_d[k] = ST_HELD;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k]         = ST_IDLE;
                        cnt_d[k]           = '0;
                        pressed_d[k]       = 1'b0;
                        release_pulse_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[k]   = ST_IDLE;
                    cnt_d[k]     = '0;
                    pressed_d[k] = 1'b0;
                end
            endcase
        end
    end

    // State, synchronizer and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            pressed_q       <= '0;
            press_pulse_q   <= '0;
            release_pulse_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    // Auto-repeat timing registers, cleared whenever a key is not held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_arm_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                rep_cnt_q[k] <= 32'd0;
            end
        end else begin
            rep_arm_q <= rep_arm_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                rep_cnt_q[k] <= rep_cnt_d[k];
            end
        end
    end
`endif

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random key
// activity, checked against a run-length reference model of the debouncer.
module tb_key_conditioner;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int CW = 3;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] pressed;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    key_conditioner #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n        (key_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: raw pressed history (the FSM sees the value from two
    // edges earlier), run lengths of the seen level, and the accepted level.
    bit hist [NK][$];
    int run1 [NK];
    int run0 [NK];
    int held [NK];
    bit prev_s [NK];
    bit acc  [NK];
    logic [NK-1:0] exp_press, exp_rel, exp_lvl;

    // Observation counters for directed checks (edges counted from clear_obs).
    int edge_no;
    int first_press [NK];
    int first_rel   [NK];
    int npress      [NK];
    int nrel        [NK];

    task automatic check_vec(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        bit s;
        for (int k = 0; k < NK; k++) begin
            exp_press[k] = 1'b0;
            exp_rel[k]   = 1'b0;
            if (reset) begin
                hist[k].delete();
                run1[k] = 0; run0[k] = 0; held[k] = 0;
                prev_s[k] = 1'b0; acc[k] = 1'b0;
            end else begin
                hist[k].push_back(~key_n[k]);
                if (hist[k].size() > 3) void'(hist[k].pop_front());
                s = (hist[k].size() == 3) ? hist[k][0] : 1'b0;
                if (s) begin run1[k]++; run0[k] = 0; end
                else   begin run0[k]++; run1[k] = 0; end
                if (!acc[k] && run1[k] >= DB + 1) begin
                    acc[k] = 1'b1; exp_press[k] = 1'b1; held[k] = 0;
                end else if (acc[k] && run0[k] >= DB + 1) begin
                    acc[k] = 1'b0; exp_rel[k] = 1'b1;
                end else if (acc[k]) begin
`ifdef KEY_AUTO_REPEAT_EN
                    held[k] = (s && prev_s[k]) ? held[k] + 1 : 0;
                    if (held[k] >= RD && ((held[k] - RD) % RP) == 0) exp_press[k] = 1'b1;
`endif
                end
                prev_s[k] = s;
            end
            exp_lvl[k] = acc[k];
        end
    endtask

    task automatic clear_obs();
        edge_no = 0;
        for (int k = 0; k < NK; k++) begin
            first_press[k] = -1; first_rel[k] = -1; npress[k] = 0; nrel[k] = 0;
        end
    endtask

    // One clock edge: update model, then sample outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        edge_no++;
        check_vec("press_pulse", press_pulse, exp_press);
        check_vec("release_pulse", release_pulse, exp_rel);
        check_vec("pressed", pressed, exp_lvl);
        check_vec("pulse_overlap", press_pulse & release_pulse, {NK{1'b0}});
        for (int k = 0; k < NK; k++) begin
            if (press_pulse[k]) begin
                npress[k]++;
                if (first_press[k] < 0) first_press[k] = edge_no;
            end
            if (release_pulse[k]) begin
                nrel[k]++;
                if (first_rel[k] < 0) first_rel[k] = edge_no;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int rem [NK];
        reset = 1'b1;
        key_n = 2'b11;
        clear_obs();
        #3;
        check_vec("reset_pressed", pressed, 2'b00);
        check_vec("reset_press_pulse", press_pulse, 2'b00);
        check_vec("reset_release_pulse", release_pulse, 2'b00);
        ticks(3);
        reset = 1'b0;

        // Hold key 0 from before edge 1: pulse after edge DB+3 only.
        key_n = 2'b10;
        clear_obs();
        ticks(12);
        check_int("press_latency", first_press[0], DB + 3);
        check_int("press_count", npress[0], 1);
        check_int("ch1_quiet", npress[1] + nrel[1], 0);

        // Stable release: one release pulse DB+3 edges later.
        key_n = 2'b11;
        clear_obs();
        ticks(12);
        check_int("release_latency", first_rel[0], DB + 3);
        check_int("release_count", nrel[0], 1);
        check_int("release_no_press", npress[0], 0);

        // Bounce: 5 x (3 low, 1 high), then held low.
        clear_obs();
        for (int r = 0; r < 5; r++) begin
            key_n[0] = 1'b0; ticks(3);
            key_n[0] = 1'b1; ticks(1);
        end
        key_n[0] = 1'b0;
        ticks(12);
        check_int("bounce_press_edge", first_press[0], 20 + DB + 3);
        check_int("bounce_press_count", npress[0], 1);
        key_n = 2'b11;
        ticks(12);

        // Both keys pressed on the same edge.
        key_n = 2'b00;
        clear_obs();
        ticks(12);
        check_int("dual_press_k0", first_press[0], DB + 3);
        check_int("dual_press_k1", first_press[1], DB + 3);
        check_int("dual_count", npress[0] + npress[1], 2);
        key_n = 2'b11;
        ticks(12);

        // Reset in the middle of PRESS_WAIT (cnt=2), key still held.
        key_n = 2'b10;
        ticks(5);
        reset = 1'b1;
        #1;
        check_vec("midreset_pressed", pressed, 2'b00);
        check_vec("midreset_pulse", press_pulse | release_pulse, 2'b00);
        ticks(2);
        reset = 1'b0;
        clear_obs();
        ticks(12);
        check_int("post_reset_press_edge", first_press[0], DB + 3);
        check_int("post_reset_press_count", npress[0], 1);

        // Reset while HELD drops pressed at once, no release pulse.
        reset = 1'b1;
        #1;
        check_vec("held_reset_pressed", pressed, 2'b00);
        ticks(1);
        reset = 1'b0;
        key_n = 2'b11;
        clear_obs();
        ticks(10);
        check_int("held_reset_no_release", nrel[0], 0);

        // Long hold: auto-repeat pulses only with the feature enabled.
        key_n = 2'b10;
        ticks(DB + 3);
        clear_obs();
        ticks(30);
`ifdef KEY_AUTO_REPEAT_EN
        check_int("repeat_count", npress[0], 7);
        check_int("repeat_first", first_press[0], RD);
`else
        check_int("repeat_count", npress[0], 0);
`endif
        key_n = 2'b11;
        ticks(DB + 3);
        clear_obs();
        ticks(15);
        check_int("after_release_no_press", npress[0], 0);

        // Random key activity on both channels, with one reset in the middle.
        for (int k = 0; k < NK; k++) rem[k] = 0;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < NK; k++) begin
                if (rem[k] == 0) begin
                    key_n[k] = 1'($urandom_range(0, 1));
                    rem[k]   = $urandom_range(1, 9);
                end
                rem[k]--;
            end
            reset = (i >= 250 && i < 252) ? 1'b1 : 1'b0;
            tick();
        end
        reset = 1'b0;
        key_n = 2'b11;
        ticks(12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
